// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// ------------
// Read-side consumer for the 8-bit synchronous FIFO. It pops one byte per
// frame and sends it LSB first on the serial line. The default frame is 8N1
// (10 bits). With FIFO_UART_TX_PARITY_EN defined, an even-parity bit is sent
// between the data bits and the stop bit (11 bits).
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (>= 2)
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   tx_enable   gates the start of new frames only
//   fifo_empty  FIFO empty flag, looked at only in IDLE
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  FIFO pop strobe, one cycle per frame
//   tx          serial line, idle high
//   busy        high in every state except IDLE
//   tx_done     one-cycle pulse on the last stop-bit cycle
//   state_o     current FSM state, for debug and checkers
//
// Handshake with the FIFO: fifo_empty low acts as "valid". fifo_rd_en is the
// "ready/pop" strobe and is asserted for exactly one cycle (POP). The FIFO's
// registered read data is captured one cycle later (LOAD). Because fifo_empty
// is ignored outside IDLE, its one-cycle lag after a pop cannot cause a second
// pop.
//
// All outputs are flops written in the FSM block. No input reaches an output
// through combinational logic only.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic [2:0] state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t          state_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_cnt_q;
  logic [CW-1:0]   baud_q;
  logic            tx_q;
  logic            rd_en_q;
  logic            busy_q;
  logic            done_q;
`ifdef FIFO_UART_TX_PARITY_EN
  logic            parity_q;
`endif

  wire baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      baud_q    <= '0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      // Strobes default low; they are set only for their single cycle.
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx_enable && !fifo_empty) begin
            state_q <= S_POP;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_POP: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          // Read data is valid now, one cycle after the pop strobe.
          shift_q <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_q <= ^fifo_data;
`endif
          state_q <= S_START;
          tx_q    <= 1'b0;
          baud_q  <= '0;
        end
        S_START: begin
          if (baud_last) begin
            state_q   <= S_DATA;
            tx_q      <= shift_q[0];
            baud_q    <= '0;
            bit_cnt_q <= 3'd0;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q    <= '0;
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= parity_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              // shift_q[1] is the bit that becomes shift_q[0] after this shift.
              tx_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_last) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
            baud_q  <= '0;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_last) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            baud_q  <= '0;
          end else begin
            baud_q <= baud_q + CW'(1);
            // Set one edge early so the registered pulse lines up with the
            // final stop-bit cycle.
            if (baud_q == BAUD_PRE) begin
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          baud_q  <= '0;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx with CLKS_PER_BIT = 4. A small FIFO model feeds
// the design. A line receiver checks every frame cycle by cycle against the
// bytes queued in exp_q.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int GAP = NB * CPB + 3;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_enable  (tx_enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .state_o    (state_o)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         starts_q[$];

  int   rd_cnt = 0;
  int   rd_dbl = 0;
  logic rd_prev = 1'b0;
  int   done_cnt = 0;
  int   frames = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- FIFO model: registered read data and empty flag ----------------
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1 && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  // ---------------- strobe monitors ----------------
  always @(negedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      rd_cnt++;
      if (rd_prev) rd_dbl++;
    end
    rd_prev = (fifo_rd_en === 1'b1);
    if (tx_done === 1'b1) done_cnt++;
  end

  // ---------------- line receiver / scoreboard ----------------
  function automatic logic line_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  logic       rx_busy = 1'b0;
  int         rx_idx = 0;
  int         rx_bad = 0;
  logic [7:0] rx_exp = 8'h00;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_last_byte = 8'h00;
  logic       rx_par = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      rx_busy = 1'b0;
    end else begin
      if (!rx_busy && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          rx_busy = 1'b1;
          rx_idx  = 0;
          rx_bad  = 0;
          rx_exp  = exp_q[0];
          rx_byte = 8'h00;
          starts_q.push_back(cyc);
        end
      end
      if (rx_busy) begin
        if (tx !== line_bit(rx_exp, rx_idx / CPB)) rx_bad++;
        if (busy !== 1'b1) rx_bad++;
        if (tx_done !== ((rx_idx == NB * CPB - 1) ? 1'b1 : 1'b0)) rx_bad++;
        if (rx_idx % CPB == CPB / 2) begin
          if (rx_idx / CPB >= 1 && rx_idx / CPB <= 8) rx_byte[rx_idx / CPB - 1] = tx;
          if (NB == 11 && rx_idx / CPB == 9) rx_par = tx;
        end
        if (rx_idx == NB * CPB - 1) begin
          check("frame_line", rx_bad, 0);
          check("rx_byte", rx_byte, exp_q.pop_front());
          rx_last_byte = rx_byte;
          frames++;
          rx_busy = 1'b0;
        end else begin
          rx_idx++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b, input bit expect_it);
    fifo_q.push_back(b);
    if (expect_it) exp_q.push_back(b);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(exp_q.size() == 0 && !rx_busy && busy === 1'b0) && n < budget);
    check({name, "_timeout"}, (n >= budget), 0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int rd0, dn0, fr0, s0, idle_bad, n;

    vecs[0] = '{data: 8'hA5, exp_par: 1'b0};
    vecs[1] = '{data: 8'h07, exp_par: 1'b1};
    vecs[2] = '{data: 8'h80, exp_par: 1'b1};
    vecs[3] = '{data: 8'h3C, exp_par: 1'b0};
    vecs[4] = '{data: 8'hFF, exp_par: 1'b0};
    vecs[5] = '{data: 8'h01, exp_par: 1'b1};

    // Reset values.
    wait_cycles(3);
    check("rst_tx", tx, 1);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_state", state_o, 0);
    @(negedge clk);
    rst = 1'b0;
    tx_enable = 1'b1;

    // Idle with an empty FIFO for 100 cycles.
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) idle_bad++;
    end
    check("idle_quiet", idle_bad, 0);
    check("idle_rd_cnt", rd_cnt, 0);

    // Single frames from the table.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd0 = rd_cnt; dn0 = done_cnt; fr0 = frames;
      push_byte(vecs[i].data, 1'b1);
      wait_done("vec", 200);
      check("vec_rd_pulses", rd_cnt - rd0, 1);
      check("vec_done_pulses", done_cnt - dn0, 1);
      check("vec_frames", frames - fr0, 1);
      check("vec_byte", rx_last_byte, vecs[i].data);
`ifdef FIFO_UART_TX_PARITY_EN
      check("vec_parity", rx_par, vecs[i].exp_par);
`endif
    end

    // Three bytes back to back.
    @(negedge clk);
    rd0 = rd_cnt; fr0 = frames; s0 = starts_q.size();
    push_byte(8'h01, 1'b1);
    push_byte(8'hFF, 1'b1);
    push_byte(8'h00, 1'b1);
    wait_done("b2b", 600);
    check("b2b_rd_pulses", rd_cnt - rd0, 3);
    check("b2b_frames", frames - fr0, 3);
    if (starts_q.size() >= s0 + 3) begin
      check("b2b_gap1", starts_q[s0 + 1] - starts_q[s0], GAP);
      check("b2b_gap2", starts_q[s0 + 2] - starts_q[s0 + 1], GAP);
    end else begin
      check("b2b_starts", starts_q.size() - s0, 3);
    end

    // tx_enable gating.
    @(negedge clk);
    tx_enable = 1'b0;
    rd0 = rd_cnt;
    push_byte(8'h96, 1'b1);
    wait_cycles(20);
    check("en_low_no_pop", rd_cnt - rd0, 0);
    check("en_low_busy", busy, 0);
    @(negedge clk);
    tx_enable = 1'b1;
    @(posedge clk); #1;
    check("en_pop_next_cycle", fifo_rd_en, 1);
    push_byte(8'h69, 1'b0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(rx_busy && rx_idx >= 10) && n < 100);
    check("en_mid_timeout", (n >= 100), 0);
    @(negedge clk);
    tx_enable = 1'b0;
    wait_done("en_frame", 200);
    wait_cycles(20);
    check("en_low_single_pop", rd_cnt - rd0, 1);
    check("en_fifo_left", fifo_q.size(), 1);
    @(negedge clk);
    exp_q.push_back(8'h69);
    tx_enable = 1'b1;
    wait_done("en_resume", 200);
    check("en_resume_pops", rd_cnt - rd0, 2);

    // Reset during data bit 3 of 0x3C; the next byte must follow cleanly.
    @(negedge clk);
    rd0 = rd_cnt; fr0 = frames;
    push_byte(8'h3C, 1'b1);
    push_byte(8'h5A, 1'b1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(rx_busy && rx_idx == 4 * CPB + 1) && n < 100);
    check("rst_mid_timeout", (n >= 100), 0);
    check("rst_mid_state_data", state_o, 4);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_state", state_o, 0);
    check("rst_mid_rd_en", fifo_rd_en, 0);
    check("rst_mid_done", tx_done, 0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_done("rst_next", 200);
    check("rst_next_pops", rd_cnt - rd0, 2);
    check("rst_next_frames", frames - fr0, 1);
    check("rst_next_byte", rx_last_byte, 8'h5A);

    check("rd_en_single_cycle", rd_dbl, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
